// File: rtl/quick_spi_arbiter.sv
// Round-robin arbiter/sequencer sharing one quick_spi master; ack one cycle after a request is seen in IDLE, done after ss_n idles.
// Requests are levels that wait while busy; optional watchdog via QUICK_SPI_ARB_TIMEOUT_EN.
module quick_spi_arbiter #(
  parameter int NUM_REQUESTERS     = 4,
  parameter int DATA_WIDTH         = 16,
  parameter int NUMBER_OF_SLAVES   = 2,
  parameter int IDLE_DETECT_CYCLES = 4,
  parameter int GAP_CYCLES         = 2,
  parameter int TIMEOUT_CYCLES     = 1024
) (
  input  logic                                   clk,
  input  logic                                   reset_n,
  input  logic [NUM_REQUESTERS-1:0]              req,
  input  logic [NUM_REQUESTERS*DATA_WIDTH-1:0]   req_data,
  input  logic [NUM_REQUESTERS*NUMBER_OF_SLAVES-1:0] req_slave,
  output logic [NUM_REQUESTERS-1:0]              req_ack,
  output logic [NUM_REQUESTERS-1:0]              req_done,
  output logic [NUM_REQUESTERS-1:0]              req_timeout,
  output logic                                   busy,
  output logic                                   spi_start_transaction,
  output logic [NUMBER_OF_SLAVES-1:0]            spi_slave,
  output logic [DATA_WIDTH-1:0]                  spi_outgoing_data,
  input  logic [NUMBER_OF_SLAVES-1:0]            spi_ss_n
);

  localparam int GW = $clog2(NUM_REQUESTERS);
  localparam logic [NUMBER_OF_SLAVES-1:0] SS_IDLE = '1;
  localparam logic [7:0] IDLE_LIM = 8'(IDLE_DETECT_CYCLES);
  localparam logic [7:0] GAP_LIM  = 8'(GAP_CYCLES);

  if (NUM_REQUESTERS < 2 || NUM_REQUESTERS > 8 || IDLE_DETECT_CYCLES < 1 ||
      IDLE_DETECT_CYCLES > 255 || GAP_CYCLES < 0 || GAP_CYCLES > 255 ||
      TIMEOUT_CYCLES < 1) begin : g_bad_params
    $error("quick_spi_arbiter: parameter out of range");
  end

  typedef enum logic [2:0] {S_IDLE, S_LAUNCH, S_WAIT_SEL, S_WAIT_DONE, S_GAP} state_t;

  state_t                      state_q, state_d;
  logic [GW-1:0]               last_grant_q, last_grant_d;
  logic [7:0]                  idle_cnt_q, idle_cnt_d;
  logic [7:0]                  gap_cnt_q, gap_cnt_d;
  logic [NUM_REQUESTERS-1:0]   req_ack_q, req_ack_d;
  logic [NUM_REQUESTERS-1:0]   req_done_q, req_done_d;
  logic                        busy_q, busy_d;
  logic                        start_q, start_d;
  logic [NUMBER_OF_SLAVES-1:0] slave_q, slave_d;
  logic [DATA_WIDTH-1:0]       data_q, data_d;
  logic                        found;
  logic [GW-1:0]               pick;
  logic                        ss_idle;

`ifdef QUICK_SPI_ARB_TIMEOUT_EN
  localparam logic [31:0] TO_LIM = 32'(TIMEOUT_CYCLES);
  logic [31:0]               wd_q, wd_d;
  logic [NUM_REQUESTERS-1:0] req_timeout_q, req_timeout_d;
`endif

  assign ss_idle = (spi_ss_n == SS_IDLE);

  // First set request strictly after the previous grant, wrapping around.
  always_comb begin
    found = 1'b0;
    pick  = last_grant_q;
    for (int k = 1; k <= NUM_REQUESTERS; k++) begin
      if (!found && req[(int'(last_grant_q) + k) % NUM_REQUESTERS]) begin
        found = 1'b1;
        pick  = GW'((int'(last_grant_q) + k) % NUM_REQUESTERS);
      end
    end
  end

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    idle_cnt_d   = idle_cnt_q;
    gap_cnt_d    = gap_cnt_q;
    req_ack_d    = '0;
    req_done_d   = '0;
    start_d      = 1'b0;
    slave_d      = slave_q;
    data_d       = data_q;
`ifdef QUICK_SPI_ARB_TIMEOUT_EN
    wd_d          = wd_q;
    req_timeout_d = '0;
`endif
    case (state_q)
      S_IDLE: begin
        if (found) begin
          state_d         = S_LAUNCH;
          last_grant_d    = pick;
          req_ack_d[pick] = 1'b1;
          start_d         = 1'b1;
          data_d          = req_data[int'(pick)*DATA_WIDTH +: DATA_WIDTH];
          slave_d         = req_slave[int'(pick)*NUMBER_OF_SLAVES +: NUMBER_OF_SLAVES];
        end
      end
      S_LAUNCH: begin
        state_d = S_WAIT_SEL;
`ifdef QUICK_SPI_ARB_TIMEOUT_EN
        wd_d = '0;
`endif
      end
      S_WAIT_SEL: begin
        if (!ss_idle) begin
          state_d    = S_WAIT_DONE;
          idle_cnt_d = '0;
        end
      end
      S_WAIT_DONE: begin
        // Short deselects between burst elements restart the idle count.
        if (!ss_idle) begin
          idle_cnt_d = '0;
        end else if (idle_cnt_q + 8'd1 >= IDLE_LIM) begin
          req_done_d[last_grant_q] = 1'b1;
          state_d   = S_GAP;
          gap_cnt_d = '0;
        end else begin
          idle_cnt_d = idle_cnt_q + 8'd1;
        end
      end
      S_GAP: begin
        if (gap_cnt_q + 8'd1 >= GAP_LIM) state_d = S_IDLE;
        else gap_cnt_d = gap_cnt_q + 8'd1;
      end
      default: state_d = S_IDLE;
    endcase
`ifdef QUICK_SPI_ARB_TIMEOUT_EN
    if (state_q == S_WAIT_SEL || state_q == S_WAIT_DONE) begin
      if (wd_q != '1) wd_d = wd_q + 32'd1;
      if (wd_q + 32'd1 >= TO_LIM && state_d != S_GAP) begin
        req_timeout_d[last_grant_q] = 1'b1;
        state_d   = S_GAP;
        gap_cnt_d = '0;
      end
    end
`endif
    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= S_IDLE;
      last_grant_q <= GW'(NUM_REQUESTERS - 1);
      idle_cnt_q   <= '0;
      gap_cnt_q    <= '0;
      req_ack_q    <= '0;
      req_done_q   <= '0;
      busy_q       <= 1'b0;
      start_q      <= 1'b0;
      slave_q      <= '0;
      data_q       <= '0;
`ifdef QUICK_SPI_ARB_TIMEOUT_EN
      wd_q          <= '0;
      req_timeout_q <= '0;
`endif
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      idle_cnt_q   <= idle_cnt_d;
      gap_cnt_q    <= gap_cnt_d;
      req_ack_q    <= req_ack_d;
      req_done_q   <= req_done_d;
      busy_q       <= busy_d;
      start_q      <= start_d;
      slave_q      <= slave_d;
      data_q       <= data_d;
`ifdef QUICK_SPI_ARB_TIMEOUT_EN
      wd_q          <= wd_d;
      req_timeout_q <= req_timeout_d;
`endif
    end
  end

  assign req_ack               = req_ack_q;
  assign req_done              = req_done_q;
  assign busy                  = busy_q;
  assign spi_start_transaction = start_q;
  assign spi_slave             = slave_q;
  assign spi_outgoing_data     = data_q;
`ifdef QUICK_SPI_ARB_TIMEOUT_EN
  assign req_timeout = req_timeout_q;
`else
  assign req_timeout = '0;
`endif

endmodule

// File: tb/tb_quick_spi_arbiter.sv
// Directed bench for quick_spi_arbiter; the bench plays the SPI master's ss_n.
`timescale 1ns/1ps
module tb_quick_spi_arbiter;
  localparam int N  = 4;
  localparam int DW = 16;
  localparam int NS = 2;

  logic            clk = 1'b0;
  logic            reset_n = 1'b0;
  logic [N-1:0]    req = '0;
  logic [N*DW-1:0] req_data = '0;
  logic [N*NS-1:0] req_slave = '0;
  logic [N-1:0]    req_ack, req_done, req_timeout;
  logic            busy, spi_start_transaction;
  logic [NS-1:0]   spi_slave;
  logic [NS-1:0]   spi_ss_n = '1;
  logic [DW-1:0]   spi_outgoing_data;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  quick_spi_arbiter #(
    .NUM_REQUESTERS(N), .DATA_WIDTH(DW), .NUMBER_OF_SLAVES(NS),
    .IDLE_DETECT_CYCLES(4), .GAP_CYCLES(2), .TIMEOUT_CYCLES(50)
  ) dut (
    .clk(clk), .reset_n(reset_n), .req(req), .req_data(req_data), .req_slave(req_slave),
    .req_ack(req_ack), .req_done(req_done), .req_timeout(req_timeout), .busy(busy),
    .spi_start_transaction(spi_start_transaction), .spi_slave(spi_slave),
    .spi_outgoing_data(spi_outgoing_data), .spi_ss_n(spi_ss_n)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ack(output logic [N-1:0] a, output bit seen);
    a = '0;
    seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      step();
      if (req_ack != '0) begin
        a = req_ack;
        seen = 1'b1;
      end
    end
  endtask

  task automatic do_ss(input int low_cycles);
    spi_ss_n = 2'b10;
    repeat (low_cycles) step();
    spi_ss_n = 2'b11;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    repeat (2) step();
    n_cmp++;
    if ({req_ack, req_done, req_timeout, busy, spi_start_transaction, spi_slave, spi_outgoing_data} !== '0) begin
      n_bad++;
      $display("FAIL reset_outputs: ack=%b done=%b to=%b busy=%b start=%b slave=%h data=%h, want all 0",
               req_ack, req_done, req_timeout, busy, spi_start_transaction, spi_slave, spi_outgoing_data);
    end
    reset_n = 1'b1;
    step();
    n_cmp++;
    if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_idle_busy: got %b want 0", busy); end
  endtask

  task automatic test_single();
    req_data[0 +: DW] = 16'hA55A;
    req_slave[0 +: NS] = 2'd1;
    req = 4'b0001;
    step();
    n_cmp++;
    if (req_ack !== 4'b0001 || spi_start_transaction !== 1'b1 || busy !== 1'b1) begin
      n_bad++; $display("FAIL single_ack: ack=%b start=%b busy=%b want 0001/1/1", req_ack, spi_start_transaction, busy);
    end
    n_cmp++;
    if (spi_outgoing_data !== 16'hA55A || spi_slave !== 2'd1) begin
      n_bad++; $display("FAIL single_data: data=%h slave=%0d want a55a/1", spi_outgoing_data, spi_slave);
    end
    req = '0;
    step();
    n_cmp++;
    if (spi_start_transaction !== 1'b0 || req_ack !== '0) begin
      n_bad++; $display("FAIL single_start_width: start=%b ack=%b want 0/0000", spi_start_transaction, req_ack);
    end
    step();
    spi_ss_n = 2'b01;
    repeat (5) step();
    spi_ss_n = 2'b11;
    repeat (3) step();
    n_cmp++;
    if (req_done !== '0) begin n_bad++; $display("FAIL single_done_early: got %b want 0000", req_done); end
    step();
    n_cmp++;
    if (req_done !== 4'b0001) begin n_bad++; $display("FAIL single_done: got %b want 0001", req_done); end
    step();
    n_cmp++;
    if (req_done !== '0 || busy !== 1'b1) begin
      n_bad++; $display("FAIL single_gap: done=%b busy=%b want 0000/1", req_done, busy);
    end
    step();
    n_cmp++;
    if (busy !== 1'b0 || spi_outgoing_data !== 16'hA55A) begin
      n_bad++; $display("FAIL single_idle: busy=%b data=%h want 0/a55a", busy, spi_outgoing_data);
    end
  endtask

  task automatic test_round_robin();
    logic [N-1:0] a, exp_g, dbits;
    bit seen;
    int dones, extra;
    reset_n = 1'b0;
    step();
    reset_n = 1'b1;
    for (int i = 0; i < N; i++) begin
      req_data[i*DW +: DW] = DW'(32'h1000 + i);
      req_slave[i*NS +: NS] = NS'(i);
    end
    req = '1;
    for (int g = 0; g < 5; g++) begin
      exp_g = 4'b0001 << (g % 4);
      wait_ack(a, seen);
      if (g == 4) req = '0;
      n_cmp++;
      if (!seen || a !== exp_g) begin
        n_bad++; $display("FAIL rr_grant%0d: got %b want %b", g, a, exp_g);
      end
      n_cmp++;
      if (spi_outgoing_data !== DW'(32'h1000 + g % 4)) begin
        n_bad++; $display("FAIL rr_data%0d: got %h want %h", g, spi_outgoing_data, DW'(32'h1000 + g % 4));
      end
      step();
      step();
      do_ss(3);
      dones = 0; extra = 0; dbits = '0;
      repeat (6) begin
        step();
        if (req_done != '0) begin dones++; dbits = req_done; end
        if (req_ack != '0) extra++;
      end
      n_cmp++;
      if (dones != 1 || dbits !== exp_g || extra != 0 || req_timeout !== '0) begin
        n_bad++; $display("FAIL rr_done%0d: dones=%0d bits=%b extra_acks=%0d, want 1/%b/0", g, dones, dbits, extra, exp_g);
      end
    end
  endtask

  task automatic test_burst_deselect();
    logic [N-1:0] a;
    bit seen, early;
    req = 4'b0100;
    wait_ack(a, seen);
    req = '0;
    n_cmp++;
    if (!seen || a !== 4'b0100) begin n_bad++; $display("FAIL burst_grant: got %b want 0100", a); end
    step();
    step();
    spi_ss_n = 2'b01;
    repeat (3) step();
    spi_ss_n = 2'b11;
    early = 1'b0;
    repeat (2) begin
      step();
      if (req_done != '0) early = 1'b1;
    end
    spi_ss_n = 2'b01;
    repeat (2) step();
    spi_ss_n = 2'b11;
    repeat (3) begin
      step();
      if (req_done != '0) early = 1'b1;
    end
    n_cmp++;
    if (early) begin n_bad++; $display("FAIL burst_no_early_done: got done during deselect, want none"); end
    step();
    n_cmp++;
    if (req_done !== 4'b0100) begin n_bad++; $display("FAIL burst_done: got %b want 0100", req_done); end
    repeat (3) step();
  endtask

  task automatic test_reset_mid();
    logic [N-1:0] a;
    bit seen;
    req = 4'b0010;
    wait_ack(a, seen);
    req = '0;
    n_cmp++;
    if (!seen || a !== 4'b0010) begin n_bad++; $display("FAIL mid_grant: got %b want 0010", a); end
    step();
    step();
    spi_ss_n = 2'b01;
    repeat (3) step();
    n_cmp++;
    if (busy !== 1'b1 || spi_outgoing_data !== 16'h1001) begin
      n_bad++; $display("FAIL mid_pre_busy: busy=%b data=%h want 1/1001", busy, spi_outgoing_data);
    end
    #2 reset_n = 1'b0;
    #1;
    n_cmp++;
    if ({req_ack, req_done, req_timeout, busy, spi_start_transaction, spi_slave, spi_outgoing_data} !== '0) begin
      n_bad++;
      $display("FAIL mid_async_reset: busy=%b slave=%h data=%h done=%b, want all 0", busy, spi_slave, spi_outgoing_data, req_done);
    end
    step();
    reset_n = 1'b1;
    spi_ss_n = 2'b11;
    req = '1;
    wait_ack(a, seen);
    req = '0;
    n_cmp++;
    if (!seen || a !== 4'b0001) begin n_bad++; $display("FAIL mid_regrant: got %b want 0001", a); end
    step();
    step();
    do_ss(2);
    repeat (8) step();
  endtask

  task automatic test_drop_before_ack();
    logic [N-1:0] a, first;
    bit seen, saw2, got;
    req = 4'b0001;
    wait_ack(a, seen);
    n_cmp++;
    if (!seen || a !== 4'b0001) begin n_bad++; $display("FAIL drop_first_grant: got %b want 0001", a); end
    req = 4'b1100;
    step();
    step();
    spi_ss_n = 2'b10;
    step();
    step();
    req = 4'b1000;
    repeat (2) step();
    spi_ss_n = 2'b11;
    saw2 = 1'b0; got = 1'b0; first = '0;
    for (int i = 0; i < 20 && !got; i++) begin
      step();
      if (req_ack[2]) saw2 = 1'b1;
      if (req_ack != '0) begin got = 1'b1; first = req_ack; end
    end
    req = '0;
    n_cmp++;
    if (!got || first !== 4'b1000 || saw2) begin
      n_bad++; $display("FAIL drop_grant3: got %b (req2 acked=%b) want 1000", first, saw2);
    end
    step();
    step();
    do_ss(2);
    repeat (8) step();
  endtask

`ifdef QUICK_SPI_ARB_TIMEOUT_EN
  task automatic test_timeout();
    logic [N-1:0] a;
    bit seen, early, done_seen;
    req = 4'b0001;
    wait_ack(a, seen);
    req = '0;
    n_cmp++;
    if (!seen || a !== 4'b0001) begin n_bad++; $display("FAIL to_grant: got %b want 0001", a); end
    step();
    early = 1'b0; done_seen = 1'b0;
    repeat (49) begin
      step();
      if (req_timeout != '0) early = 1'b1;
      if (req_done != '0) done_seen = 1'b1;
    end
    n_cmp++;
    if (early) begin n_bad++; $display("FAIL to_early: timeout before 50 cycles, want none"); end
    step();
    n_cmp++;
    if (req_timeout !== 4'b0001 || req_done !== '0) begin
      n_bad++; $display("FAIL to_pulse: timeout=%b done=%b want 0001/0000", req_timeout, req_done);
    end
    step();
    step();
    n_cmp++;
    if (busy !== 1'b0 || done_seen || req_timeout !== '0) begin
      n_bad++; $display("FAIL to_idle: busy=%b done_seen=%b want 0/0", busy, done_seen);
    end
  endtask
`else
  task automatic test_timeout();
    logic [N-1:0] a;
    bit seen, to_seen;
    req = 4'b0001;
    wait_ack(a, seen);
    req = '0;
    n_cmp++;
    if (!seen || a !== 4'b0001) begin n_bad++; $display("FAIL nowd_grant: got %b want 0001", a); end
    to_seen = 1'b0;
    repeat (60) begin
      step();
      if (req_timeout != '0) to_seen = 1'b1;
    end
    n_cmp++;
    if (to_seen || busy !== 1'b1) begin
      n_bad++; $display("FAIL nowd_stuck: timeout_seen=%b busy=%b want 0/1", to_seen, busy);
    end
    reset_n = 1'b0;
    step();
    reset_n = 1'b1;
  endtask
`endif

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_burst_deselect();
    test_reset_mid();
    test_drop_before_ack();
    test_timeout();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: bench did not finish, want completion");
    $fatal(1, "bench time limit");
  end

endmodule
